// File: rtl/cussen_pkg.sv
// cussen_pkg: shared sizes and FSM state encoding for the cussen expander
package cussen_pkg;
  localparam int N = 9;
  localparam int W = 8;
  localparam int PW = 4;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
endpackage

// File: rtl/cussen_lookup.sv
// cussen_lookup: table lookup with range check against the count clamped to N
module cussen_lookup #(
  parameter int N = cussen_pkg::N,
  parameter int W = cussen_pkg::W,
  parameter int PW = cussen_pkg::PW
) (
  input  logic [W-1:0]  tbl [N],
  input  logic [PW-1:0] ptr,
  input  logic [PW-1:0] cnt,
  output logic [W-1:0]  val,
  output logic          err
);
  logic [PW-1:0] eff;
  always_comb begin
    eff = cnt > PW'(N) ? PW'(N) : cnt;
    err = ptr >= eff;
    val = err ? '0 : tbl[ptr];
  end
endmodule

// File: rtl/cussen_expand.sv
// cussen_expand: rebuilds an N-element vector from a unique table and pointers, one element per cycle
module cussen_expand
  import cussen_pkg::*;
#(
  parameter int N = cussen_pkg::N,
  parameter int W = cussen_pkg::W,
  parameter int PW = cussen_pkg::PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] unique_count,
  input  logic [W-1:0]  uniq1, uniq2, uniq3, uniq4, uniq5, uniq6, uniq7, uniq8, uniq9,
  input  logic [PW-1:0] ptr1, ptr2, ptr3, ptr4, ptr5, ptr6, ptr7, ptr8, ptr9,
  output logic [W-1:0]  out1, out2, out3, out4, out5, out6, out7, out8, out9,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  err_mask
);
  state_t state, nxt;
  logic [PW-1:0] k, cnt_q;
  logic [W-1:0] uin [N];
  logic [PW-1:0] pin [N];
  logic [W-1:0] uq [N];
  logic [PW-1:0] pq [N];
  logic [W-1:0] oq [N];
  logic [N-1:0] err_q;
  logic [W-1:0] val;
  logic bad, acc;
  assign uin = '{uniq1, uniq2, uniq3, uniq4, uniq5, uniq6, uniq7, uniq8, uniq9};
  assign pin = '{ptr1, ptr2, ptr3, ptr4, ptr5, ptr6, ptr7, ptr8, ptr9};
  assign {out1, out2, out3, out4, out5, out6, out7, out8, out9} =
    {oq[0], oq[1], oq[2], oq[3], oq[4], oq[5], oq[6], oq[7], oq[8]};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign err_mask = err_q;
  assign acc = in_valid && in_ready;
  cussen_lookup #(.N(N), .W(W), .PW(PW)) u_lookup (
    .tbl(uq), .ptr(pq[k]), .cnt(cnt_q), .val(val), .err(bad)
  );
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = in_valid ? EXPAND : IDLE;
    else if (state == EXPAND) nxt = k == PW'(N - 1) ? DONE : EXPAND;
    else if (state == DONE) nxt = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // inputs are snapshotted on acceptance; the walk only ever reads the snapshot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k <= '0;
      cnt_q <= '0;
      err_q <= '0;
      oq <= '{default: '0};
    end else if (acc) begin
      uq <= uin;
      pq <= pin;
      cnt_q <= unique_count;
      k <= '0;
    end else if (state == EXPAND) begin
      oq[k] <= val;
      err_q[k] <= bad;
      k <= k + 1'b1;
    end
  end
endmodule

// File: tb/tb_cussen_expand.sv
// tb_cussen_expand: randomized and directed checks of cussen_expand against a behavioural model
module tb_cussen_expand;
  logic clk = 0;
  logic rst_n, in_valid, out_ready, in_ready, out_valid;
  logic [3:0] uc;
  logic [7:0] u [9];
  logic [3:0] p [9];
  logic [7:0] o [9];
  logic [8:0] em;
  logic [7:0] eo [9];
  logic [8:0] ee;
  logic [7:0] lit [9];
  logic armed;
  int checks, errors;

  always #5 clk = ~clk;

  cussen_expand dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .unique_count(uc),
    .uniq1(u[0]), .uniq2(u[1]), .uniq3(u[2]), .uniq4(u[3]), .uniq5(u[4]),
    .uniq6(u[5]), .uniq7(u[6]), .uniq8(u[7]), .uniq9(u[8]),
    .ptr1(p[0]), .ptr2(p[1]), .ptr3(p[2]), .ptr4(p[3]), .ptr5(p[4]),
    .ptr6(p[5]), .ptr7(p[6]), .ptr8(p[7]), .ptr9(p[8]),
    .out1(o[0]), .out2(o[1]), .out3(o[2]), .out4(o[3]), .out5(o[4]),
    .out6(o[5]), .out7(o[6]), .out8(o[7]), .out9(o[8]),
    .out_valid(out_valid), .out_ready(out_ready), .err_mask(em)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    int eff;
    eff = uc > 9 ? 9 : int'(uc);
    for (int k = 0; k < 9; k++) begin
      eo[k] = int'(p[k]) < eff ? u[p[k]] : 8'd0;
      ee[k] = int'(p[k]) >= eff;
    end
  endtask

  task automatic scramble();
    uc = 4'($urandom);
    for (int k = 0; k < 9; k++) begin
      u[k] = 8'($urandom);
      p[k] = 4'($urandom);
    end
  endtask

  always @(negedge clk) begin
    if (armed && out_valid) begin
      for (int k = 0; k < 9; k++) chk("out", 32'(o[k]), 32'(eo[k]));
      chk("err_mask", 32'(em), 32'(ee));
      chk("in_ready_done", 32'(in_ready), 0);
    end
  end

  task automatic accept();
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
    model();
    in_valid = 1;
    @(posedge clk);
    #1;
    armed = 1;
    in_valid = 0;
  endtask

  task automatic wait_done();
    int lat;
    lat = 0;
    do begin
      scramble();
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid) chk("in_ready_busy", 32'(in_ready), 0);
    end while (!out_valid && lat < 20);
    in_valid = 0;
    out_ready = 0;
    chk("latency", lat, 9);
  endtask

  task automatic drain(input int hold);
    for (int i = 0; i < hold; i++) begin
      scramble();
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    in_valid = 0;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_ready", 32'(in_ready), 1);
  endtask

  task automatic chk_lit(input logic [8:0] le);
    for (int k = 0; k < 9; k++) chk("lit_out", 32'(o[k]), 32'(lit[k]));
    chk("lit_err", 32'(em), 32'(le));
  endtask

  task automatic chk_zero();
    for (int k = 0; k < 9; k++) chk("zero_out", 32'(o[k]), 0);
    chk("zero_err", 32'(em), 0);
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_ready", 32'(in_ready), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    armed = 0;
    rst_n = 0;
    in_valid = 1;
    out_ready = 1;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    out_ready = 0;
    chk_zero();

    uc = 1;
    u = '{9, 0, 0, 0, 0, 0, 0, 0, 0};
    p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    accept();
    wait_done();
    lit = '{9, 9, 9, 9, 9, 9, 9, 9, 9};
    chk_lit(9'h000);
    drain(0);

    uc = 5;
    u = '{3, 1, 4, 5, 9, 0, 0, 0, 0};
    p = '{0, 1, 2, 1, 3, 4, 1, 1, 1};
    accept();
    wait_done();
    lit = '{3, 1, 4, 1, 5, 9, 1, 1, 1};
    chk_lit(9'h000);
    drain(0);

    uc = 2;
    u = '{7, 6, 0, 0, 0, 0, 0, 0, 0};
    p = '{0, 1, 2, 0, 1, 8, 0, 0, 15};
    accept();
    wait_done();
    lit = '{7, 6, 0, 7, 6, 0, 7, 7, 0};
    chk_lit(9'b100100100);
    drain(5);
    chk_lit(9'b100100100);

    uc = 15;
    u = '{10, 11, 12, 13, 14, 15, 16, 17, 18};
    p = '{8, 7, 6, 5, 4, 3, 2, 9, 0};
    accept();
    wait_done();
    lit = '{18, 17, 16, 15, 14, 13, 12, 0, 10};
    chk_lit(9'b010000000);
    drain(1);

    scramble();
    accept();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    out_ready = 0;
    armed = 0;
    chk_zero();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("no_partial_valid", 32'(out_valid), 0);
    end

    uc = 0;
    u = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    p = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    accept();
    wait_done();
    lit = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_lit(9'h1FF);
    drain(2);

    for (int r = 0; r < 30; r++) begin
      scramble();
      if (r % 3 == 0) for (int k = 0; k < 9; k++) p[k] = 4'($urandom_range(0, 9));
      accept();
      wait_done();
      drain($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cussen_expand.md
CUSSEN_EXPAND -- requirements
Module: cussen_expand

Interface
REQ-001 The module SHALL have parameter N, default 9, the number of elements per vector.
REQ-002 The module SHALL have parameter W, default 8, the element data width.
REQ-003 The module SHALL have parameter PW, default 4, the pointer and count width.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  a compressed vector is present on the inputs.
REQ-007 in_ready  output  1  the block accepts a vector on this cycle.
REQ-008 unique_count  input  PW  number of valid unique-table entries.
REQ-009 uniq1..uniq9  input  W each  unique-value table, entry index 0..8.
REQ-010 ptr1..ptr9  input  PW each  table index for each output element.
REQ-011 out1..out9  output  W each  reconstructed vector.
REQ-012 out_valid  output  1  out1..out9 and err_mask are complete and stable.
REQ-013 out_ready  input  1  the consumer accepts the vector.
REQ-014 err_mask  output  N  bit k-1 is set when ptrk was out of range.

Function
REQ-015 The module SHALL implement an FSM with three states:
- IDLE, where in_ready=1.
- EXPAND, which walks element index k=0..N-1, one per cycle.
- DONE, where out_valid=1.
REQ-016 A vector SHALL be accepted on an edge where in_valid&&in_ready.
- All uniq, ptr and unique_count inputs are captured into internal registers.
- k is cleared, and IDLE->EXPAND.
REQ-017 The captured registers SHALL be used exclusively afterwards; input changes after acceptance SHALL have no effect.
REQ-018 Each EXPAND edge SHALL write element k and increment k.
- If ptr_k < effective count: out_{k+1} = uniq[ptr_k] and err_mask[k] = 0.
- Otherwise: out_{k+1} = 0 and err_mask[k] = 1.
REQ-019 The effective count SHALL be min(unique_count, 9); values 10..15 are treated as 9.
REQ-020 unique_count=0 SHALL mark every element as an error: all outputs 0 and err_mask = 9'h1FF.
REQ-021 On the edge that writes element k=N-1 the FSM SHALL go EXPAND->DONE, so out_valid rises exactly 9 edges after the accepting edge.
REQ-022 out1..out9 and err_mask SHALL hold their values while out_valid=1 and until the next acceptance.
REQ-023 out_valid SHALL stay high until an edge with out_ready=1; on that edge DONE->IDLE and out_valid=0.
REQ-024 in_ready SHALL be 0 in EXPAND and DONE.
- A new vector is accepted no earlier than the edge after the DONE->IDLE edge.
- There is no combinational path from out_ready to in_ready.
REQ-025 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-026 Duplicate pointers SHALL be legal, and unused table entries SHALL be ignored.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, k=0, out1..out9=0, err_mask=0, out_valid=0 and in_ready=1 from the following cycle.
REQ-028 A reset during EXPAND or DONE SHALL discard the vector in progress with no partial out_valid.
REQ-029 A reset SHALL take precedence over a simultaneous in_valid or out_ready.

Structure
REQ-030 A shared package cussen_pkg SHALL hold the constants N=9, W=8 and PW=4, and the FSM state encoding (IDLE, EXPAND, DONE).
REQ-031 The index-to-value lookup with range check SHALL be one sub-module, cussen_lookup.
- Combinational: table, pointer and count in; value and error bit out.
- Instantiated once and shared across the EXPAND cycles.

Verification
REQ-032 The bench SHALL drive unique_count=1, uniq1=9 and ptr1..ptr9=0.
- Required: out1..out9=9 and err_mask=0.
- out_valid rises 9 edges after acceptance.
REQ-033 The bench SHALL drive unique_count=5 with uniq=3,1,4,5,9 and ptrs=0,1,2,1,3,4,1,1,1.
- Required: outputs 3,1,4,1,5,9,1,1,1 and err_mask=0.
REQ-034 The bench SHALL drive unique_count=2 with uniq1=7, uniq2=6 and ptrs=0,1,2,0,1,8,0,0,15.
- Required: outputs 7,6,0,7,6,0,7,7,0 and err_mask=9'b100100100.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE while changing the inputs and pulsing in_valid.
- Required: outputs stable, out_valid=1 and in_ready=0 throughout.
- After out_ready=1 for one edge: IDLE, with the next vector accepted the following edge.
REQ-036 The bench SHALL assert rst_n=0 for one edge at the 4th EXPAND edge.
- Required: out_valid=0, all outputs 0 and in_ready=1 on the next cycle.
- A following vector with unique_count=0 yields err_mask=9'h1FF and all outputs 0.
